// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// word geometry used by the loader and its byte packer.
package imem_pkg;

    localparam int INSTR_W         = 32;
    localparam int BYTES_PER_INSTR = 4;
    localparam int PC_STEP         = 4;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_INSTR);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHK   = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage : imem_pkg

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer. Byte k of a word lands in bits
// [8k+7:8k]; word_ready_o pulses combinationally on the cycle the last byte
// of a word is accepted, and the index wraps back to 0 on that edge.
module byte_packer
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               accept_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] word_o,
    output logic               word_ready_o
);

    localparam logic [BYTE_IDX_W-1:0] IDX_LAST = BYTE_IDX_W'(BYTES_PER_INSTR - 1);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [INSTR_W-1:0]    word_q, word_d;

    // Next index and word: clear restarts a word, an accepted byte fills its lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            idx_d                        = idx_q + BYTE_IDX_W'(1);
        end
    end

    // Index and word registers; a reset discards any partial word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = accept_i && !clear_i && (idx_q == IDX_LAST);

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream over valid/ready, packs
// little-endian 32-bit words and writes one per WRITE cycle at 4-byte steps,
// holding the CPU while loading.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit XOR
// checksum word (CHK state) that drives Error on mismatch.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                LEN_W     = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [LEN_W-1:0]   LoadLen,
    input  logic [7:0]         ByteIn,
    input  logic               ByteValid,
    output logic               ByteReady,
    output logic               IMWrite,
    output logic [ADDR_W-1:0]  IMAddr,
    output logic [INSTR_W-1:0] IMData,
    output logic               CPUHold,
    output logic               Done,
    output logic               Error
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                start_ok;
    logic                accept;
    logic                word_ready;
    logic [INSTR_W-1:0]  word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0]  xor_q, xor_d;
    logic                err_q, err_d;
    logic [INSTR_W-1:0]  chk_word;

    // The 4th checksum byte is still on ByteIn when word_ready fires.
    assign chk_word = {ByteIn, word[INSTR_W-9:0]};
`endif

    assign start_ok = Start && (state_q == IDLE || state_q == DONE);
    assign accept   = ByteValid && ByteReady;

    byte_packer u_packer (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .clear_i      (start_ok),
        .accept_i     (accept),
        .byte_i       (ByteIn),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    // Next-state logic for the load sequence, address and remaining count.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    rem_d   = LoadLen;
                    addr_d  = BASE_ADDR;
                    state_d = (LoadLen == '0) ? DONE : RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            RECV: begin
                if (word_ready) state_d = WRITE;
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(PC_STEP);
                rem_d  = rem_q - LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d   = xor_q ^ word;
                state_d = (rem_q == LEN_W'(1)) ? CHK : RECV;
`else
                state_d = (rem_q == LEN_W'(1)) ? DONE : RECV;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (word_ready) begin
                    err_d   = (chk_word != xor_q);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, address and count registers with asynchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            rem_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ByteReady = (state_q == RECV) || (state_q == CHK);
    assign IMWrite   = (state_q == WRITE);
    assign CPUHold   = (state_q == RECV) || (state_q == WRITE) || (state_q == CHK);
    assign Done      = (state_q == DONE);
    assign IMAddr    = addr_q;
    assign IMData    = word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign Error     = err_q;
`else
    assign Error     = 1'b0;
`endif

endmodule : imem_loader
